gb_timer: RTL
=============

Name: gb_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer unit beside the CPU datapath on the I/O bus (0xFF04-0xFF07).
- Driven by the datapath's bus strobes; returns read data to the datapath's MDR path.
- Produces a one-cycle timer interrupt request consumed by the interrupt flag logic feeding the control path.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC at +1/+2/+3.
- CNT_W, 16, width of the internal system counter; DIV is bits [CNT_W-1:CNT_W-8].

Ports:
- clk  input  1  system clock (4.194304 MHz T-cycle clock)
- rst  input  1  asynchronous, active-low reset
- addr  input  16  bus address from datapath
- wdata  input  8  bus write data
- we  input  1  write strobe, one clk per access
- re  input  1  read strobe
- rdata  output  8  read data, combinational from addr
- hit  output  1  addr in BASE_ADDR..BASE_ADDR+3
- timer_irq  output  1  one-clk pulse on TIMA reload

Behaviour:
- Reset (rst low, async): cnt=0, TIMA=0, TMA=0, TAC=0, prev_sig=0, state=RUN, timer_irq=0. rdata tracks the reset register values.
- cnt increments by 1 every clk and wraps 0xFFFF->0x0000. DIV reads cnt[15:8].
- Tap bit by TAC[1:0]: 00->cnt[9] (1024 clk), 01->cnt[3] (16), 10->cnt[5] (64), 11->cnt[7] (256).
- sig = TAC[2] & tap. TIMA increment event = prev_sig & ~sig (falling edge). prev_sig<=sig every clk.
- sig is computed from post-write cnt/TAC, so a DIV write or TAC write can create a falling edge and an increment (deliberate hardware-accurate glitch).
- Reads: DIV, TIMA, TMA as stored; TAC returns {5'b11111, TAC[2:0]}. With hit=0, rdata=8'hFF. Reads have no side effects; re is ignored internally.
- Writes (we & hit, take effect at the clk edge):
  - DIV: cnt<=0 (any wdata).
  - TIMA: TIMA<=wdata.
  - TMA: TMA<=wdata.
  - TAC: TAC<=wdata[2:0].
- FSM:
  - RUN: on an increment event with TIMA==8'hFF, TIMA<=8'h00 and go to RELOAD. Otherwise an increment event gives TIMA<=TIMA+1.
  - RELOAD (exactly one clk): TIMA<=TMA, timer_irq=1 (registered, high for this clk only), return to RUN.
- Simultaneous events:
  - TIMA write in the same clk as an increment: the write wins and the increment is dropped.
  - TIMA write during RELOAD: the write wins, no reload, but timer_irq still fires.
  - TMA write during RELOAD: TIMA takes the new wdata, not the old TMA.
  - An increment event during RELOAD is dropped.
- Latency: from falling edge of sig to the TIMA update is 1 clk. From overflow, TIMA=TMA and timer_irq=1 one clk later.
- Reset asserted mid-RELOAD: immediate return to reset values, no irq pulse.

Decomposition:
- Shared package (gb_pkg):
  - register offset constants DIV_OFF..TAC_OFF;
  - typedef enum logic {RUN, RELOAD} timer_state_t;
  - typedef enum logic [1:0] tac_clk_sel_t.
- One natural sub-module: gb_timer_edge, which holds the tap mux, prev_sig flop and falling-edge detector.

Test Plan:
1. Reset release, no writes, 256 clk -> DIV reads 8'h01. After 65536 clk DIV wraps to 8'h00. TIMA stays 8'h00 (TAC=0).
2. TAC=3'b101, TIMA=8'h00 -> TIMA reads 8'h01 16 clk after the first cnt[3] falling edge, and 8'h10 after 256 clk.
3. TMA=8'hF0, TIMA=8'hFF, TAC=3'b101 -> on the next increment TIMA=8'h00 for 1 clk, then 8'hF0. timer_irq is high exactly 1 clk.
4. TAC=3'b100, advance until cnt[9]=1, write DIV -> cnt=0 and TIMA increments by 1. With TAC[2]=0, the same write gives no increment.
5. Force an overflow and write TIMA=8'h42 in the RELOAD clk -> TIMA=8'h42 and timer_irq still pulses. Repeat with a TMA write of 8'h77 instead -> TIMA=8'h77.
6. Read 0xFF07 with TAC=3'b010 -> rdata=8'hFA. Read 0xFF08 -> hit=0, rdata=8'hFF. Assert rst low during RELOAD -> all registers 0, timer_irq 0 immediately.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer block.
package gb_pkg;

  localparam logic [1:0] DIV_OFF  = 2'd0;
  localparam logic [1:0] TIMA_OFF = 2'd1;
  localparam logic [1:0] TMA_OFF  = 2'd2;
  localparam logic [1:0] TAC_OFF  = 2'd3;

  typedef enum logic {
    RUN    = 1'b0,
    RELOAD = 1'b1
  } timer_state_t;

  // Encoding matches TAC[1:0]; names give the input clock period in clk.
  typedef enum logic [1:0] {
    TAC_1024 = 2'b00,
    TAC_16   = 2'b01,
    TAC_64   = 2'b10,
    TAC_256  = 2'b11
  } tac_clk_sel_t;

endpackage

// File: rtl/gb_timer_if.sv
// I/O bus slice seen by the timer: datapath strobes in, MDR read data out.
interface gb_timer_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic [7:0]  rdata;
  logic        hit;

  modport master (output addr, wdata, we, re, input rdata, hit);
  modport slave  (input addr, wdata, we, re, output rdata, hit);
endinterface

// File: rtl/gb_timer_edge.sv
// TAC tap select plus falling-edge detect; inc is the TIMA increment event.
module gb_timer_edge
  import gb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] taps,   // indexed by TAC[1:0]
  input  logic [2:0] tac,
  output logic       inc
);
  tac_clk_sel_t sel;
  logic tap, sig, prev_sig;

  assign sel = tac_clk_sel_t'(tac[1:0]);

  always_comb begin
    tap = taps[0];
    case (sel)
      TAC_1024: tap = taps[0];
      TAC_16:   tap = taps[1];
      TAC_64:   tap = taps[2];
      TAC_256:  tap = taps[3];
      default:  tap = taps[0];
    endcase
  end

  // Built from the already-written cnt/TAC, so a DIV or TAC write can itself
  // pull sig low and produce an increment.
  assign sig = tac[2] & tap;
  assign inc = prev_sig & ~sig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_sig <= 1'b0;
    else      prev_sig <= sig;
  end
endmodule

// File: rtl/gb_timer.sv
// Memory-mapped DIV/TIMA/TMA/TAC timer with one-clk overflow reload delay.
module gb_timer
  import gb_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter int unsigned CNT_W     = 16
) (
  input  logic      clk,
  input  logic      rst,
  gb_timer_if.slave bus,
  output logic      timer_irq
);
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tima, tma, rd;
  logic [2:0]       tac;
  timer_state_t     state;
  logic [15:0]      off;
  logic             hit, inc;
  logic             wr_div, wr_tima, wr_tma, wr_tac;

  assign off     = bus.addr - BASE_ADDR;
  assign hit     = (off[15:2] == '0);
  assign wr_div  = bus.we & hit & (off[1:0] == DIV_OFF);
  assign wr_tima = bus.we & hit & (off[1:0] == TIMA_OFF);
  assign wr_tma  = bus.we & hit & (off[1:0] == TMA_OFF);
  assign wr_tac  = bus.we & hit & (off[1:0] == TAC_OFF);

  gb_timer_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .taps ({cnt[7], cnt[5], cnt[3], cnt[9]}),
    .tac  (tac),
    .inc  (inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      tma <= '0;
      tac <= '0;
    end else begin
      cnt <= wr_div ? '0 : cnt + CNT_W'(1);
      if (wr_tma) tma <= bus.wdata;
      if (wr_tac) tac <= bus.wdata[2:0];
    end
  end

  // Overflow leaves TIMA at 00 for one clk; the reload and irq land together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      tima      <= '0;
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (state == RELOAD);
      case (state)
        RUN: begin
          if (wr_tima) tima <= bus.wdata;
          else if (inc) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= RELOAD;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        RELOAD: begin
          state <= RUN;
          if (wr_tima || wr_tma) tima <= bus.wdata;
          else                   tima <= tma;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    rd = 8'hFF;
    if (hit) begin
      case (off[1:0])
        DIV_OFF:  rd = cnt[CNT_W-1 -: 8];
        TIMA_OFF: rd = tima;
        TMA_OFF:  rd = tma;
        TAC_OFF:  rd = {5'b11111, tac};
        default:  rd = 8'hFF;
      endcase
    end
  end

  assign bus.rdata = rd;
  assign bus.hit   = hit;
endmodule
